// File: rtl/sprite_addr_calc.sv
// Per-sprite pixel address generator: maps a raster position onto a sprite
// memory address, handling tiling, horizontal flip and horizontal scroll.
module sprite_addr_calc #(
  parameter int ADDR_W  = 16,
  parameter int COORD_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5*ADDR_W-1:0]    pattern_info,
  input  logic [3*COORD_W+1:0]   sprite_info,
  input  logic [COORD_W-1:0]     hcount,
  input  logic [COORD_W-1:0]     vcount,
  output logic [ADDR_W-1:0]      addr_output,
  output logic                   valid
);

  // Extended width holds signed pixel offsets and unsigned pattern sizes together
  localparam int EXT_W = ADDR_W + 2;

  logic [ADDR_W-1:0]  base_s;
  logic [ADDR_W-1:0]  tile_w_s;
  logic [ADDR_W-1:0]  tile_h_s;
  logic [ADDR_W-1:0]  disp_w_s;
  logic [ADDR_W-1:0]  disp_h_s;
  logic               visible_s;
  logic               flip_s;
  logic [COORD_W-1:0] x_s;
  logic [COORD_W-1:0] y_s;
  logic [COORD_W-1:0] shift_s;

  logic signed [COORD_W+1:0] left_s;
  logic signed [COORD_W:0]   row_s;
  logic signed [EXT_W-1:0]   col_ext_s;
  logic signed [EXT_W-1:0]   row_ext_s;
  logic signed [EXT_W-1:0]   disp_w_ext_s;
  logic signed [EXT_W-1:0]   disp_h_ext_s;
  logic                      inside_s;
  logic [ADDR_W-1:0]         colf_s;
  logic [ADDR_W-1:0]         tc_s;
  logic [ADDR_W-1:0]         tr_s;
  logic [ADDR_W-1:0]         addr_s;

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              valid_d, valid_q;

  assign base_s    = pattern_info[5*ADDR_W-1:4*ADDR_W];
  assign tile_w_s  = pattern_info[4*ADDR_W-1:3*ADDR_W];
  assign tile_h_s  = pattern_info[3*ADDR_W-1:2*ADDR_W];
  assign disp_w_s  = pattern_info[2*ADDR_W-1:ADDR_W];
  assign disp_h_s  = pattern_info[ADDR_W-1:0];

  assign visible_s = sprite_info[3*COORD_W+1];
  assign flip_s    = sprite_info[3*COORD_W];
  assign x_s       = sprite_info[3*COORD_W-1:2*COORD_W];
  assign y_s       = sprite_info[2*COORD_W-1:COORD_W];
  assign shift_s   = sprite_info[COORD_W-1:0];

  // Left edge may go negative when the sprite is scrolled off the left side
  assign left_s       = {2'b00, x_s} - {2'b00, shift_s};
  assign row_s        = {1'b0, vcount} - {1'b0, y_s};
  assign col_ext_s    = {{(EXT_W-COORD_W){1'b0}}, hcount}
                      - {{(EXT_W-COORD_W-2){left_s[COORD_W+1]}}, left_s};
  assign row_ext_s    = {{(EXT_W-COORD_W-1){row_s[COORD_W]}}, row_s};
  assign disp_w_ext_s = {2'b00, disp_w_s};
  assign disp_h_ext_s = {2'b00, disp_h_s};

  assign inside_s = visible_s
                  && !col_ext_s[EXT_W-1] && (col_ext_s < disp_w_ext_s)
                  && !row_ext_s[EXT_W-1] && (row_ext_s < disp_h_ext_s)
                  && (tile_w_s != {ADDR_W{1'b0}})
                  && (tile_h_s != {ADDR_W{1'b0}});

  always_comb begin
    colf_s = col_ext_s[ADDR_W-1:0];
    if (flip_s) begin
      colf_s = disp_w_s - ADDR_W'(1) - col_ext_s[ADDR_W-1:0];
    end else begin
      colf_s = col_ext_s[ADDR_W-1:0];
    end
  end

  // Tile sizes are powers of two, so wrapping reduces to masking
  assign tc_s   = colf_s & (tile_w_s - ADDR_W'(1));
  assign tr_s   = row_ext_s[ADDR_W-1:0] & (tile_h_s - ADDR_W'(1));
  assign addr_s = base_s + (tr_s * tile_w_s) + tc_s;

  always_comb begin
    addr_d  = {ADDR_W{1'b1}};
    valid_d = 1'b0;
    if (inside_s) begin
      addr_d  = addr_s;
      valid_d = 1'b1;
    end else begin
      addr_d  = {ADDR_W{1'b1}};
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= {ADDR_W{1'b1}};
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign addr_output = addr_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_sprite_addr_calc.sv
// Directed self-checking bench for sprite_addr_calc with hand-computed vectors.
module tb_sprite_addr_calc;

  logic        clk;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [15:0] addr_output;
  logic        valid;

  int n_checks;
  int n_fail;

  sprite_addr_calc #(.ADDR_W(16), .COORD_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_info (pattern_info),
    .sprite_info  (sprite_info),
    .hcount       (hcount),
    .vcount       (vcount),
    .addr_output  (addr_output),
    .valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] pat(input logic [15:0] base, input logic [15:0] tw,
                                      input logic [15:0] th, input logic [15:0] dw,
                                      input logic [15:0] dh);
    return {base, tw, th, dw, dh};
  endfunction

  function automatic logic [31:0] spr(input logic vis, input logic flip, input logic [9:0] x,
                                      input logic [9:0] y, input logic [9:0] sh);
    return {vis, flip, x, y, sh};
  endfunction

  task automatic chk(input string tag, input logic ev, input logic [15:0] ea);
    n_checks++;
    assert (valid === ev) else begin
      n_fail++;
      $error("FAIL %s valid observed=%0b expected=%0b", tag, valid, ev);
    end
    n_checks++;
    assert (addr_output === ea) else begin
      n_fail++;
      $error("FAIL %s addr observed=%h expected=%h", tag, addr_output, ea);
    end
  endtask

  task automatic step(input string tag, input logic [9:0] h, input logic [9:0] v,
                      input logic ev, input logic [15:0] ea);
    @(negedge clk);
    hcount = h;
    vcount = v;
    @(posedge clk);
    #1;
    chk(tag, ev, ea);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    pattern_info = pat(16'd0, 16'd32, 16'd16, 16'd32, 16'd16);
    sprite_info  = spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
    hcount       = 10'd100;
    vcount       = 10'd50;
    #2;
    chk("reset_state", 1'b0, 16'hFFFF);

    // Release reset mid-cycle; outputs must hold until the next edge
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("hold_after_reset", 1'b0, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("corner_top_left", 1'b1, 16'd0);

    step("corner_bottom_right", 10'd131, 10'd65, 1'b1, 16'd511);
    step("right_exclusive",     10'd132, 10'd65, 1'b0, 16'hFFFF);
    step("bottom_exclusive",    10'd131, 10'd66, 1'b0, 16'hFFFF);
    step("above_top",           10'd100, 10'd49, 1'b0, 16'hFFFF);
    step("interior",            10'd110, 10'd53, 1'b1, 16'd106);

    // Asynchronous reset while valid is high
    #2;
    reset = 1'b1;
    #1;
    chk("reset_async", 1'b0, 16'hFFFF);
    @(negedge clk);
    reset = 1'b0;

    sprite_info = spr(1'b1, 1'b1, 10'd100, 10'd50, 10'd0);
    step("flip_left",  10'd100, 10'd50, 1'b1, 16'd31);
    step("flip_right", 10'd131, 10'd50, 1'b1, 16'd0);
    step("flip_row",   10'd101, 10'd52, 1'b1, 16'd94);

    pattern_info = pat(16'd544, 16'd32, 16'd1, 16'd32, 16'd128);
    sprite_info  = spr(1'b1, 1'b0, 10'd100, 10'd66, 10'd0);
    step("vtile_first", 10'd105, 10'd100, 1'b1, 16'd549);
    step("vtile_last",  10'd105, 10'd193, 1'b1, 16'd549);
    step("vtile_below", 10'd105, 10'd194, 1'b0, 16'hFFFF);

    pattern_info = pat(16'd0, 16'd32, 16'd16, 16'd32, 16'd16);
    sprite_info  = spr(1'b1, 1'b0, 10'd200, 10'd0, 10'd100);
    step("scroll_left_edge", 10'd100, 10'd0, 1'b1, 16'd0);
    step("scroll_outside",   10'd99,  10'd0, 1'b0, 16'hFFFF);
    sprite_info  = spr(1'b0, 1'b0, 10'd200, 10'd0, 10'd100);
    step("invisible_a", 10'd100, 10'd0, 1'b0, 16'hFFFF);
    step("invisible_b", 10'd120, 10'd7, 1'b0, 16'hFFFF);

    sprite_info = spr(1'b1, 1'b0, 10'd10, 10'd5, 10'd20);
    step("negative_left", 10'd0, 10'd5, 1'b1, 16'd10);

    // 8x4 tiles over a 32x16 sprite: col 13 -> tc 5, row 6 -> tr 2
    pattern_info = pat(16'd100, 16'd8, 16'd4, 16'd32, 16'd16);
    sprite_info  = spr(1'b1, 1'b0, 10'd0, 10'd0, 10'd0);
    step("htile_mask", 10'd13, 10'd6, 1'b1, 16'd121);

    pattern_info = pat(16'hFFF0, 16'd32, 16'd16, 16'd32, 16'd16);
    step("addr_wrap", 10'd20, 10'd0, 1'b1, 16'h0004);

    pattern_info = pat(16'd0, 16'd32, 16'd16, 16'd0, 16'd16);
    step("disp_w_zero", 10'd0, 10'd0, 1'b0, 16'hFFFF);
    pattern_info = pat(16'd0, 16'd32, 16'd16, 16'd32, 16'd0);
    step("disp_h_zero", 10'd0, 10'd0, 1'b0, 16'hFFFF);
    pattern_info = pat(16'd0, 16'd0, 16'd16, 16'd32, 16'd16);
    step("tile_w_zero", 10'd0, 10'd0, 1'b0, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
